// File: rtl/axi_sram_slave.sv
// AXI3 slave endpoint backed by an on-chip 32-bit word RAM.
// Serves one transaction at a time (read or write). Supports INCR/FIXED
// bursts of 1-16 beats, per-byte write strobes and OKAY/SLVERR responses.
// Address bits above the RAM depth must be zero; otherwise the beat is
// flagged as an error, writes are dropped and reads return zero.
module axi_sram_slave #(
    parameter int AWIDTH     = 32,
    parameter int IWIDTH     = 12,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic              clk,
    input  logic              resetn,
    // write address channel
    input  logic [IWIDTH-1:0] awid_i,
    input  logic [AWIDTH-1:0] awaddr_i,
    input  logic [3:0]        awlen_i,
    input  logic [1:0]        awburst_i,
    input  logic              awvalid_i,
    output logic              awready_o,
    // write data channel
    input  logic [31:0]       wdata_i,
    input  logic [3:0]        wstrb_i,
    input  logic              wlast_i,
    input  logic              wvalid_i,
    output logic              wready_o,
    // write response channel
    output logic [IWIDTH-1:0] bid_o,
    output logic [1:0]        bresp_o,
    output logic              bvalid_o,
    input  logic              bready_i,
    // read address channel
    input  logic [IWIDTH-1:0] arid_i,
    input  logic [AWIDTH-1:0] araddr_i,
    input  logic [3:0]        arlen_i,
    input  logic [1:0]        arburst_i,
    input  logic              arvalid_i,
    output logic              arready_o,
    // read data channel
    output logic [IWIDTH-1:0] rid_o,
    output logic [31:0]       rdata_o,
    output logic [1:0]        rresp_o,
    output logic              rvalid_o,
    output logic              rlast_o,
    input  logic              rready_i
);

    localparam int WAW = AWIDTH - 2;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WDATA  = 3'd1;
    localparam logic [2:0] S_WRESP  = 3'd2;
    localparam logic [2:0] S_RFETCH = 3'd3;
    localparam logic [2:0] S_RDATA  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic              rr_last_q, rr_last_d;
    logic [IWIDTH-1:0] id_q, id_d;
    logic [WAW-1:0]    addr_q, addr_d;
    logic [3:0]        len_q, len_d;
    logic [1:0]        burst_q, burst_d;
    logic              err_q, err_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [1:0]        rresp_q, rresp_d;
    logic              rlast_q, rlast_d;
    logic [31:0]       rdata_q;

    logic [31:0] mem [0:(1 << DEPTH_LOG2) - 1];

    logic                  grantW, grantR;
    logic                  beatOor, lastBeat, memWe;
    logic [DEPTH_LOG2-1:0] idx;
    logic [WAW-1:0]        addrNext;
    logic                  unused_addr_bits;

    // Byte-offset bits are meaningless with fixed 32-bit transfers.
    assign unused_addr_bits = ^{awaddr_i[1:0], araddr_i[1:0]};

    assign idx      = addr_q[DEPTH_LOG2-1:0];
    assign beatOor  = |addr_q[WAW-1:DEPTH_LOG2];
    assign lastBeat = (cnt_q == len_q);
    assign addrNext = (burst_q == 2'b00) ? addr_q : addr_q + {{(WAW-1){1'b0}}, 1'b1};

    // Round-robin arbitration only matters when both address channels request.
    assign grantW = awvalid_i && (!arvalid_i || rr_last_q);
    assign grantR = arvalid_i && (!awvalid_i || !rr_last_q);

    assign awready_o = (state_q == S_IDLE) && grantW;
    assign arready_o = (state_q == S_IDLE) && grantR;
    assign wready_o  = (state_q == S_WDATA);
    assign bvalid_o  = (state_q == S_WRESP);
    assign rvalid_o  = (state_q == S_RDATA);
    assign bid_o     = id_q;
    assign rid_o     = id_q;
    assign bresp_o   = err_q ? 2'b10 : 2'b00;
    assign rresp_o   = rresp_q;
    assign rlast_o   = rlast_q;
    assign rdata_o   = rdata_q;

    assign memWe = resetn && (state_q == S_WDATA) && wvalid_i && !beatOor;

    // Next-state logic for the transaction sequencer.
    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
        id_d      = id_q;
        addr_d    = addr_q;
        len_d     = len_q;
        burst_d   = burst_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        case (state_q)
            S_IDLE: begin
                if (grantW) begin
                    id_d      = awid_i;
                    addr_d    = awaddr_i[AWIDTH-1:2];
                    len_d     = awlen_i;
                    burst_d   = awburst_i;
                    err_d     = (awburst_i == 2'b11);
                    cnt_d     = 4'd0;
                    rr_last_d = 1'b0;
                    state_d   = S_WDATA;
                end else if (grantR) begin
                    id_d      = arid_i;
                    addr_d    = araddr_i[AWIDTH-1:2];
                    len_d     = arlen_i;
                    burst_d   = arburst_i;
                    err_d     = (arburst_i == 2'b11);
                    cnt_d     = 4'd0;
                    rr_last_d = 1'b1;
                    state_d   = S_RFETCH;
                end
            end
            S_WDATA: begin
                if (wvalid_i) begin
                    if (beatOor || (wlast_i != lastBeat)) begin
                        err_d = 1'b1;
                    end
                    if (lastBeat) begin
                        state_d = S_WRESP;
                    end else begin
                        cnt_d  = cnt_q + 4'd1;
                        addr_d = addrNext;
                    end
                end
            end
            S_WRESP: begin
                if (bready_i) begin
                    state_d = S_IDLE;
                end
            end
            S_RFETCH: begin
                rresp_d = (err_q || beatOor) ? 2'b10 : 2'b00;
                rlast_d = lastBeat;
                state_d = S_RDATA;
            end
            S_RDATA: begin
                if (rready_i) begin
                    if (rlast_q) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d   = cnt_q + 4'd1;
                        addr_d  = addrNext;
                        state_d = S_RFETCH;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; read data is captured from RAM during the fetch cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            rr_last_q <= 1'b0;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            burst_q   <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            rresp_q   <= 2'b00;
            rlast_q   <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            burst_q   <= burst_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
            if (state_q == S_RFETCH) begin
                rdata_q <= beatOor ? 32'd0 : mem[idx];
            end
        end
    end

    // RAM byte-lane writes; contents survive reset.
    always_ff @(posedge clk) begin
        if (memWe) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb_i[i]) begin
                    mem[idx][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

endmodule
